matmul_job_sequencer: RTL and testbench

- Sequences one complete 4x4 matrix-multiply job around the matrix_multiplication block and its A/B/C RAMs.
- Accepts A then B operand words from a host stream and writes them into the RAMs through the programming port.
- Then raises start_mat_mul, waits for done_mat_mul under a watchdog, reads C back and streams it to the host.
- Owns the shared RAM programming port: the engine has the RAMs only while this block is in RUN.

---
 rtl/matmul_seq_pkg.sv | 24 ++
 rtl/matmul_watchdog.sv | 29 ++
 rtl/matmul_job_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_matmul_job_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_seq_pkg.sv
// Shared types and constants for the matrix-multiply job sequencer.
package matmul_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_RD_REQ = 3'd4,
    ST_RD_RSP = 3'd5
  } seq_state_e;

  // Words per 4x4 matrix (four 8-bit elements packed per word)
  localparam int SEQ_NWORDS  = 4;
  // Default watchdog limit in RUN, in cycles
  localparam int SEQ_TIMEOUT = 255;

  // A, B and C each live in their own RAM starting at these addresses
  localparam int A_BASE_ADDR = 0;
  localparam int B_BASE_ADDR = 0;
  localparam int C_BASE_ADDR = 0;

endpackage

// File: rtl/matmul_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT.
module matmul_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Count enabled cycles, saturating at TIMEOUT; clear has priority
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(TIMEOUT))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // The current enabled cycle is the TIMEOUT-th one since clear
  assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/matmul_job_sequencer.sv
// Runs one 4x4 matrix-multiply job: loads A and B from the host stream into
// the operand RAMs, starts the engine under a watchdog, then streams C back.
// The RAM programming port is only released to the engine while in RUN.
module matmul_job_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 7,
  parameter int NWORDS  = SEQ_NWORDS,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_go,
  output logic          busy,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          we_a,
  output logic          we_b,
  output logic          enable_writing_to_mem,
  output logic          enable_reading_from_mem,
  input  logic [DW-1:0] mem_rdata,
  output logic          start_mat_mul,
  input  logic          done_mat_mul,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          job_done,
  output logic          err_timeout
);

  localparam logic [AW-1:0] LAST_CNT = AW'(NWORDS - 1);
  localparam logic [AW-1:0] A_BASE   = AW'(A_BASE_ADDR);
  localparam logic [AW-1:0] B_BASE   = AW'(B_BASE_ADDR);
  localparam logic [AW-1:0] C_BASE   = AW'(C_BASE_ADDR);

  seq_state_e    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          err_timeout_reg, err_timeout_next;
  logic          rsp_first_reg;
  logic [DW-1:0] out_data_reg;
  logic          wdog_clear;
  logic          wdog_enable;
  logic          wdog_expired;

  // The watchdog only runs in RUN and restarts from zero on every entry
  assign wdog_enable = (state_reg == ST_RUN);
  assign wdog_clear  = (state_reg != ST_RUN);

  matmul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdog_clear),
    .enable  (wdog_enable),
    .expired (wdog_expired)
  );

  // State, word counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  // C read-back holding register: RAM data is presented directly in the
  // first RD_RSP cycle and latched so it stays stable under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_first_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      rsp_first_reg <= (state_reg == ST_RD_REQ);
      if (rsp_first_reg) begin
        out_data_reg <= mem_rdata;
      end
    end
  end

  assign out_data    = rsp_first_reg ? mem_rdata : out_data_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign err_timeout = err_timeout_reg;

  // Next-state logic and all decoded port-control outputs
  always_comb begin
    state_next              = state_reg;
    cnt_next                = cnt_reg;
    err_timeout_next        = err_timeout_reg;
    in_ready                = 1'b0;
    mem_addr                = '0;
    mem_wdata               = '0;
    we_a                    = 1'b0;
    we_b                    = 1'b0;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    start_mat_mul           = 1'b0;
    out_valid               = 1'b0;
    job_done                = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_go) begin
          err_timeout_next = 1'b0;
          cnt_next         = '0;
          state_next       = ST_LOAD_A;
        end
      end

      ST_LOAD_A: begin
        in_ready              = 1'b1;
        enable_writing_to_mem = 1'b1;
        mem_addr              = A_BASE + cnt_reg;
        if (in_valid) begin
          we_a      = 1'b1;
          mem_wdata = in_data;
          if (cnt_reg == LAST_CNT) begin
            cnt_next   = '0;
            state_next = ST_LOAD_B;
          end else begin
            cnt_next = cnt_reg + AW'(1);
          end
        end
      end

      ST_LOAD_B: begin
        in_ready              = 1'b1;
        enable_writing_to_mem = 1'b1;
        mem_addr              = B_BASE + cnt_reg;
        if (in_valid) begin
          we_b      = 1'b1;
          mem_wdata = in_data;
          if (cnt_reg == LAST_CNT) begin
            cnt_next   = '0;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg + AW'(1);
          end
        end
      end

      ST_RUN: begin
        start_mat_mul = 1'b1;
        // A completion in the very cycle the watchdog expires still counts
        if (done_mat_mul) begin
          cnt_next   = '0;
          state_next = ST_RD_REQ;
        end else if (wdog_expired) begin
          err_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        enable_reading_from_mem = 1'b1;
        mem_addr                = C_BASE + cnt_reg;
        state_next              = ST_RD_RSP;
      end

      ST_RD_RSP: begin
        // Keep the address up so the RAM keeps returning the same word
        enable_reading_from_mem = 1'b1;
        mem_addr                = C_BASE + cnt_reg;
        out_valid               = 1'b1;
        if (out_ready) begin
          if (cnt_reg == LAST_CNT) begin
            job_done   = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next   = cnt_reg + AW'(1);
            state_next = ST_RD_REQ;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Scoreboard bench for matmul_job_sequencer with RAM and engine models.
module tb_matmul_job_sequencer;
  import matmul_seq_pkg::*;

  localparam int DW        = 32;
  localparam int AW        = 7;
  localparam int ENG_DELAY = 20;

  localparam logic [DW-1:0] LOAD_WORDS [8] = '{
    32'h0905_0308, 32'h0102_0304, 32'h0001_0306, 32'h0506_0708,
    32'h0003_0101, 32'h0304_0100, 32'h0103_0503, 32'h0203_0609};
  localparam logic [DW-1:0] C_WORDS [4] = '{
    32'h2252_5A62, 32'h1A33_3F4B, 32'h132C_303E, 32'h0D2E_2836};

  typedef struct packed {
    logic          sel_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_go;
  logic          busy;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          we_a;
  logic          we_b;
  logic          enable_writing_to_mem;
  logic          enable_reading_from_mem;
  logic [DW-1:0] mem_rdata;
  logic          start_mat_mul;
  logic          done_mat_mul;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          job_done;
  logic          err_timeout;

  logic          eng_done;
  logic          eng_hang;
  logic          spur_done;
  int            eng_cnt;
  logic [DW-1:0] c_mem [0:(1<<AW)-1];

  wr_t           wq [$];
  logic [DW-1:0] cq [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            jd_count = 0;
  int            out_count = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  assign done_mat_mul = eng_done | spur_done;

  matmul_job_sequencer #(
    .DW      (DW),
    .AW      (AW),
    .NWORDS  (SEQ_NWORDS),
    .TIMEOUT (SEQ_TIMEOUT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_go                  (cmd_go),
    .busy                    (busy),
    .in_data                 (in_data),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .we_a                    (we_a),
    .we_b                    (we_b),
    .enable_writing_to_mem   (enable_writing_to_mem),
    .enable_reading_from_mem (enable_reading_from_mem),
    .mem_rdata               (mem_rdata),
    .start_mat_mul           (start_mat_mul),
    .done_mat_mul            (done_mat_mul),
    .out_data                (out_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .job_done                (job_done),
    .err_timeout             (err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Engine model: clears C at start, publishes C and pulses done after ENG_DELAY cycles
  always @(posedge clk) begin
    if (reset || !start_mat_mul) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_cnt  <= eng_cnt + 1;
      eng_done <= 1'b0;
      if (eng_cnt == 0) begin
        for (int i = 0; i < SEQ_NWORDS; i++) c_mem[C_BASE_ADDR + i] <= '0;
      end
      if (!eng_hang && eng_cnt == ENG_DELAY - 1) begin
        eng_done <= 1'b1;
        for (int i = 0; i < SEQ_NWORDS; i++) c_mem[C_BASE_ADDR + i] <= C_WORDS[i];
      end
    end
  end

  // C RAM with one-cycle registered read
  always @(posedge clk) begin
    if (enable_reading_from_mem) mem_rdata <= c_mem[mem_addr];
  end

  // Monitor: sample away from the active edge, pop scoreboards on transactions
  always @(negedge clk) begin
    wr_t           e;
    logic [DW-1:0] c;
    if (!reset) begin
      if (prev_stall) begin
        check("out_hold_valid", out_valid, 1);
        check("out_hold_data", out_data, prev_data);
      end
      if (we_a || we_b) begin
        $display("WR %s addr=%0d data=0x%08h", we_b ? "B" : "A", mem_addr, mem_wdata);
        check("we_onehot", we_a & we_b, 0);
        check("wr_grant", enable_writing_to_mem, 1);
        check("wr_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_sel", we_b, e.sel_b);
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (out_valid && out_ready) begin
        $display("OUT data=0x%08h job_done=%0b", out_data, job_done);
        out_count++;
        check("c_expected", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          c = cq.pop_front();
          check("c_data", out_data, c);
          check("job_done_last", job_done, cq.size() == 0);
        end
      end else if (job_done) begin
        check("job_done_hs", out_valid && out_ready, 1);
      end
      if (job_done) jd_count++;
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_data  = out_data;
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {busy, in_ready, we_a, we_b, enable_writing_to_mem,
                          enable_reading_from_mem, start_mat_mul, out_valid,
                          job_done, err_timeout}, '0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_out"}, out_data, 0);
  endtask

  task automatic abort_reset(input string tag);
    reset = 1'b1; cmd_go = 1'b0; in_valid = 1'b0; out_ready = 1'b0; spur_done = 1'b0;
    @(posedge clk); #1;
    check_zero(tag);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    wq.delete();
    cq.delete();
    $display("RESET %s done", tag);
  endtask

  // abort: 0 none, 1 reset during RUN, 2 reset during RD_RSP
  task automatic run_job(input bit bubble, input bit stall, input bit spur,
                         input bit hang, input int abort);
    int  jd0, out0, waits, nb, n, stall_cnt;
    wr_t e;
    jd0  = jd_count;
    out0 = out_count;
    eng_hang = hang;
    if (!hang) for (int i = 0; i < SEQ_NWORDS; i++) cq.push_back(C_WORDS[i]);
    $display("JOB bubble=%0b stall=%0b spur=%0b hang=%0b abort=%0d", bubble, stall, spur, hang, abort);
    cmd_go = 1'b1;
    @(posedge clk); #1;
    cmd_go = 1'b0;
    check("go_busy", busy, 1);
    check("go_err_clear", err_timeout, 0);
    waits = 0;
    for (int i = 0; i < 2 * SEQ_NWORDS; i++) begin
      if (bubble && i > 0) begin
        in_valid = 1'b0;
        if (spur && i >= SEQ_NWORDS) begin cmd_go = 1'b1; spur_done = 1'b1; end
        @(posedge clk); #1;
        cmd_go = 1'b0; spur_done = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = LOAD_WORDS[i];
      e.sel_b  = (i >= SEQ_NWORDS);
      e.addr   = AW'(((i >= SEQ_NWORDS) ? B_BASE_ADDR : A_BASE_ADDR) + (i % SEQ_NWORDS));
      e.data   = LOAD_WORDS[i];
      wq.push_back(e);
      nb = 0;
      @(negedge clk);
      while (!in_ready && nb < 50) begin @(negedge clk); nb++; end
      waits += nb;
      check("load_ready", in_ready, 1);
      if (!in_ready) begin in_valid = 1'b0; return; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!bubble) check("load_back_to_back", waits, 0);
    check("start_after_load", start_mat_mul, 1);
    check("wq_drained", wq.size(), 0);

    if (hang) begin
      n = 0;
      while (start_mat_mul && n < 1000) begin @(posedge clk); #1; n++; end
      check("wdog_cycles", n, SEQ_TIMEOUT);
      check("wdog_err", err_timeout, 1);
      check("wdog_idle", busy, 0);
      check("wdog_no_job_done", jd_count - jd0, 0);
      eng_hang = 1'b0;
      return;
    end

    n = 0; stall_cnt = 0;
    while (busy && n < 2000) begin
      if (abort == 1 && start_mat_mul && n >= 5) begin abort_reset("rst_run"); return; end
      if (abort == 2 && out_valid && (out_count - out0) >= 1) begin abort_reset("rst_rsp"); return; end
      if (stall && out_valid && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
        if (spur) begin cmd_go = 1'b1; spur_done = 1'b1; in_valid = 1'b1; in_data = $urandom; end
      end else begin
        out_ready = 1'b1;
        if (out_valid) stall_cnt = 0;
      end
      @(posedge clk); #1;
      cmd_go = 1'b0; spur_done = 1'b0; in_valid = 1'b0;
      n++;
    end
    out_ready = 1'b1;
    check("job_complete", busy, 0);
    check("job_done_pulses", jd_count - jd0, 1);
    check("c_all_out", cq.size(), 0);
    check("no_err", err_timeout, 0);
  endtask

  initial begin
    reset = 1'b1; cmd_go = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; eng_hang = 1'b0; spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);   // nominal
    run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);   // bubbles and backpressure
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 0);   // watchdog abort
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", err_timeout, 1);
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);   // cmd_go clears the flag
    run_job(1'b1, 1'b1, 1'b1, 1'b0, 0);   // spurious inputs
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1);   // reset during RUN
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_job(1'b0, 1'b1, 1'b0, 1'b0, 2);   // reset during RD_RSP
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

endmodule
